ctrl_vendas: RTL and testbench

- Main sequencing FSM of the vending machine.
- Accumulates inserted coins as credit, validates a product selection against its price, and drives LP (liberar produto) or DM (devolver moeda) into the end-of-operation timer.
- Holds that request until the timer's FIM rises, then waits for FIM to clear before accepting a new transaction.
- Runs on the same 1 s divided clock as the FIM timer.

---
 rtl/ctrl_vendas.sv | 204 ++++++++++++++++++++
 tb/tb_ctrl_vendas.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_vendas.sv
// ctrl_vendas: main sequencing FSM of the vending machine.
//
// Accumulates coins as credit (units of R$0,25), checks a product selection
// against its price and requests either product release (LP) or coin return
// (DM) from the end-of-operation timer. The request is held until FIM rises,
// then the controller waits for FIM to clear before a new transaction starts.
//
// Ports:
//   clk        1 s divided clock, all logic on posedge
//   rst        synchronous active-high reset
//   M25/M50/M100  single-cycle coin pulses worth 1/2/4 units
//   SEL        product index, sampled with CONF
//   CONF       confirm purchase pulse
//   CANC       cancel / refund pulse (wins over CONF)
//   FIM        end-of-operation flag from the timer
//   LP / DM    release product / return coins, held until FIM=1
//   CRED       current credit
//   TROCO      change or refund amount
//   REJ        one-cycle pulse, coin rejected
//   NEG        one-cycle pulse, insufficient credit
//   OCUP       busy (delivering, refunding or clearing)
module ctrl_vendas #(
  parameter int unsigned W        = 8,
  parameter int unsigned PRECO_A  = 6,
  parameter int unsigned PRECO_B  = 8,
  parameter int unsigned PRECO_C  = 10,
  parameter int unsigned PRECO_D  = 12,
  parameter int unsigned MAX_CRED = 16,
  parameter int unsigned TIMEOUT  = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         M25,
  input  logic         M50,
  input  logic         M100,
  input  logic [1:0]   SEL,
  input  logic         CONF,
  input  logic         CANC,
  input  logic         FIM,
  output logic         LP,
  output logic         DM,
  output logic [W-1:0] CRED,
  output logic [W-1:0] TROCO,
  output logic         REJ,
  output logic         NEG,
  output logic         OCUP
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StCredito,
    StEntrega,
    StDevolve,
    StLimpa
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    cred_q, cred_d;
  logic [W-1:0]    troco_q, troco_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            lp_q, lp_d;
  logic            dm_q, dm_d;
  logic            rej_q, rej_d;
  logic            neg_q, neg_d;
  logic            ocup_q, ocup_d;

  logic [1:0]      num_coins;
  logic            coin_any;
  logic [W:0]      coin_val;
  logic [W:0]      cred_sum;
  logic            accepting;
  logic            coin_ok;
  logic [W-1:0]    price;

  // Coin decode; one extra bit on the sum so an overflow cannot wrap past MAX_CRED.
  always_comb begin
    num_coins = {1'b0, M25} + {1'b0, M50} + {1'b0, M100};
    coin_any  = M25 | M50 | M100;
    if (M100) begin
      coin_val = (W+1)'(4);
    end else if (M50) begin
      coin_val = (W+1)'(2);
    end else begin
      coin_val = (W+1)'(1);
    end
    cred_sum  = {1'b0, cred_q} + coin_val;
    accepting = (state_q == StIdle) || (state_q == StCredito);
    coin_ok   = accepting && (num_coins == 2'd1) && !CONF && !CANC &&
                (cred_sum <= (W+1)'(MAX_CRED));
  end

  always_comb begin
    unique case (SEL)
      2'd0:    price = W'(PRECO_A);
      2'd1:    price = W'(PRECO_B);
      2'd2:    price = W'(PRECO_C);
      default: price = W'(PRECO_D);
    endcase
  end

  always_comb begin
    state_d = state_q;
    cred_d  = cred_q;
    troco_d = troco_q;
    cnt_d   = cnt_q;
    neg_d   = 1'b0;
    rej_d   = coin_any && !coin_ok;

    unique case (state_q)
      StIdle: begin
        if (coin_ok) begin
          cred_d  = cred_sum[W-1:0];
          cnt_d   = '0;
          state_d = StCredito;
        end else if (CONF && !CANC) begin
          neg_d = 1'b1;
        end
      end
      StCredito: begin
        if (CANC) begin
          troco_d = cred_q;
          cred_d  = '0;
          cnt_d   = '0;
          state_d = StDevolve;
        end else if (CONF) begin
          if (cred_q >= price) begin
            troco_d = cred_q - price;
            cred_d  = '0;
            cnt_d   = '0;
            state_d = StEntrega;
          end else begin
            neg_d = 1'b1;
          end
        end else if (coin_ok) begin
          cred_d = cred_sum[W-1:0];
          cnt_d  = '0;
        end else if (!coin_any) begin
          // Quiet cycle: refund automatically once the idle budget is used up.
          if (cnt_q == CntW'(TIMEOUT - 1)) begin
            troco_d = cred_q;
            cred_d  = '0;
            cnt_d   = '0;
            state_d = StDevolve;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StEntrega, StDevolve: begin
        if (FIM) begin
          state_d = StLimpa;
        end
      end
      StLimpa: begin
        if (!FIM) begin
          troco_d = '0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    lp_d   = (state_d == StEntrega);
    dm_d   = (state_d == StDevolve);
    ocup_d = (state_d == StEntrega) || (state_d == StDevolve) || (state_d == StLimpa);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cred_q  <= '0;
      troco_q <= '0;
      cnt_q   <= '0;
      lp_q    <= 1'b0;
      dm_q    <= 1'b0;
      rej_q   <= 1'b0;
      neg_q   <= 1'b0;
      ocup_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cred_q  <= cred_d;
      troco_q <= troco_d;
      cnt_q   <= cnt_d;
      lp_q    <= lp_d;
      dm_q    <= dm_d;
      rej_q   <= rej_d;
      neg_q   <= neg_d;
      ocup_q  <= ocup_d;
    end
  end

  assign LP    = lp_q;
  assign DM    = dm_q;
  assign CRED  = cred_q;
  assign TROCO = troco_q;
  assign REJ   = rej_q;
  assign NEG   = neg_q;
  assign OCUP  = ocup_q;

endmodule

// File: tb/tb_ctrl_vendas.sv
// Testbench for ctrl_vendas: directed scenarios followed by random traffic.
// A transaction-level reference model predicts the outputs after every clock
// edge; predictions are queued and a separate monitor compares them.
module tb_ctrl_vendas;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       M25 = 1'b0, M50 = 1'b0, M100 = 1'b0;
  logic [1:0] SEL = 2'd0;
  logic       CONF = 1'b0, CANC = 1'b0, FIM = 1'b0;
  logic       LP, DM, REJ, NEG, OCUP;
  logic [7:0] CRED, TROCO;

  ctrl_vendas dut (
    .clk   (clk),
    .rst   (rst),
    .M25   (M25),
    .M50   (M50),
    .M100  (M100),
    .SEL   (SEL),
    .CONF  (CONF),
    .CANC  (CANC),
    .FIM   (FIM),
    .LP    (LP),
    .DM    (DM),
    .CRED  (CRED),
    .TROCO (TROCO),
    .REJ   (REJ),
    .NEG   (NEG),
    .OCUP  (OCUP)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cred;
    int troco;
    bit lp;
    bit dm;
    bit rej;
    bit neg;
    bit ocup;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model: one vending transaction at a time.
  int price[4] = '{6, 8, 10, 12};
  int m_cred = 0, m_troco = 0, m_quiet = 0;
  bit m_session = 0;    // credit has been inserted and a sale is open
  int m_dispense = 0;   // 0 none, 1 product being released, 2 coins being returned
  bit m_clearing = 0;   // request finished, waiting for the timer flag to drop

  // Timer model driving FIM from the predicted LP/DM.
  bit fim_v = 0;
  int t_cnt = 0, t_hold = 0;
  bit glitch_en = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  task automatic refund();
    m_troco    = m_cred;
    m_cred     = 0;
    m_dispense = 2;
    m_session  = 0;
  endtask

  task automatic model_step(input bit r, input bit a25, input bit a50, input bit a100,
                            input bit cf, input bit cn, input bit [1:0] s, input bit f);
    exp_t e;
    int   n, val;
    bit   coin, active, ok, rej, neg;
    n      = int'(a25) + int'(a50) + int'(a100);
    val    = a100 ? 4 : (a50 ? 2 : 1);
    coin   = (n > 0);
    active = (m_dispense == 0) && !m_clearing;
    ok     = active && (n == 1) && !cf && !cn && (m_cred + val <= 16);
    rej    = coin && !ok;
    neg    = 0;
    if (r) begin
      m_cred = 0; m_troco = 0; m_quiet = 0;
      m_session = 0; m_dispense = 0; m_clearing = 0;
      rej = 0;
    end else if (m_dispense != 0) begin
      if (f) begin
        m_dispense = 0;
        m_clearing = 1;
      end
    end else if (m_clearing) begin
      if (!f) begin
        m_clearing = 0;
        m_troco    = 0;
      end
    end else if (!m_session) begin
      if (ok) begin
        m_cred    = m_cred + val;
        m_session = 1;
        m_quiet   = 0;
      end else if (cf && !cn) begin
        neg = 1;
      end
    end else begin
      if (cn) begin
        refund();
      end else if (cf) begin
        if (m_cred >= price[s]) begin
          m_troco    = m_cred - price[s];
          m_cred     = 0;
          m_dispense = 1;
          m_session  = 0;
        end else begin
          neg = 1;
        end
      end else if (ok) begin
        m_cred  = m_cred + val;
        m_quiet = 0;
      end else if (!coin) begin
        if (m_quiet == 29) refund();
        else m_quiet++;
      end
    end
    e.cred  = m_cred;
    e.troco = m_troco;
    e.lp    = (m_dispense == 1);
    e.dm    = (m_dispense == 2);
    e.rej   = rej;
    e.neg   = neg;
    e.ocup  = (m_dispense != 0) || m_clearing;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs at the falling edge and predict the result.
  task automatic step(input bit r, input bit a25, input bit a50, input bit a100,
                      input bit cf, input bit cn, input bit [1:0] s);
    bit lpdm;
    @(negedge clk);
    lpdm = (m_dispense != 0);
    if (lpdm) begin
      t_cnt++;
      if (t_cnt >= 4 && !fim_v) begin
        fim_v  = 1;
        t_hold = 1;
      end
    end else if (fim_v) begin
      t_cnt = 0;
      if (t_hold > 0) t_hold--;
      else fim_v = 0;
    end else begin
      t_cnt = 0;
      if (glitch_en && $urandom_range(0, 15) == 0) begin
        fim_v  = 1;
        t_hold = 0;
      end
    end
    rst  = r;
    M25  = a25;
    M50  = a50;
    M100 = a100;
    CONF = cf;
    CANC = cn;
    SEL  = s;
    FIM  = fim_v;
    model_step(r, a25, a50, a100, cf, cn, s, fim_v);
    if (r) t_cnt = 0;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 2'd0);
  endtask

  // Let a pending release/refund run to completion, bounded.
  task automatic drain();
    int budget;
    budget = 40;
    while ((m_dispense != 0 || m_clearing) && budget > 0) begin
      step(0, 0, 0, 0, 0, 0, 2'd0);
      budget--;
    end
    n_cmp++;
    if (budget == 0) begin
      n_bad++;
      $display("FAIL drain cycle %0d: got busy after 40 cycles, expected idle", cyc);
    end
  endtask

  // Monitor: compare every cycle's outputs with the oldest prediction.
  always begin
    exp_t e;
    @(posedge clk);
    cyc++;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("CRED",  {24'd0, CRED},  e.cred);
      check("TROCO", {24'd0, TROCO}, e.troco);
      check("LP",    {31'd0, LP},    {31'd0, e.lp});
      check("DM",    {31'd0, DM},    {31'd0, e.dm});
      check("REJ",   {31'd0, REJ},   {31'd0, e.rej});
      check("NEG",   {31'd0, NEG},   {31'd0, e.neg});
      check("OCUP",  {31'd0, OCUP},  {31'd0, e.ocup});
      check("LP_DM_EXCL", {31'd0, LP & DM}, 32'd0);
    end
  end

  initial begin
    int qleft;
    bit r, a25, a50, a100, cf, cn;
    int c;
    // Reset, then buy product 0 with exact credit.
    step(1, 0, 0, 0, 0, 0, 2'd0);
    step(1, 0, 0, 0, 0, 0, 2'd0);
    step(0, 0, 1, 0, 0, 0, 2'd0);
    step(0, 0, 0, 1, 0, 0, 2'd0);
    step(0, 0, 0, 0, 1, 0, 2'd0);
    drain();
    // Product 1 with change.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 2'd0);
    step(0, 0, 0, 0, 1, 0, 2'd1);
    drain();
    // Insufficient credit, then cancel.
    step(0, 1, 0, 0, 0, 0, 2'd0);
    step(0, 0, 0, 0, 1, 0, 2'd3);
    step(0, 0, 0, 0, 0, 1, 2'd0);
    drain();
    // Fill to the credit ceiling, overflow and double coin rejects.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 2'd0);
    step(0, 1, 0, 0, 0, 0, 2'd0);
    step(0, 1, 1, 0, 0, 0, 2'd0);
    step(0, 0, 0, 0, 0, 1, 2'd0);
    drain();
    // Idle timeout refund.
    step(0, 0, 1, 0, 0, 0, 2'd0);
    quiet(31);
    drain();
    // Reset during delivery.
    step(0, 0, 0, 1, 0, 0, 2'd0);
    step(0, 0, 1, 0, 0, 0, 2'd0);
    step(0, 0, 0, 0, 1, 0, 2'd0);
    quiet(1);
    step(1, 0, 0, 0, 0, 0, 2'd0);
    quiet(2);
    // CONF and CANC together with credit 8: cancel wins.
    step(0, 0, 0, 1, 0, 0, 2'd0);
    step(0, 0, 0, 1, 0, 0, 2'd0);
    step(0, 0, 0, 0, 1, 1, 2'd2);
    drain();
    // Random traffic.
    glitch_en = 1;
    qleft = 0;
    for (int i = 0; i < 3000; i++) begin
      if (qleft > 0) begin
        quiet(1);
        qleft--;
      end else begin
        r    = ($urandom_range(0, 399) == 0);
        c    = $urandom_range(0, 15);
        a25  = (c == 0) || (c == 3) || (c == 5);
        a50  = (c == 1) || (c == 3);
        a100 = (c == 2) || (c == 4) || (c == 5);
        cf   = ($urandom_range(0, 9) == 0);
        cn   = ($urandom_range(0, 24) == 0);
        step(r, a25, a50, a100, cf, cn, 2'($urandom_range(0, 3)));
        if ($urandom_range(0, 59) == 0) qleft = 32;
      end
    end
    glitch_en = 0;
    quiet(2);
    @(posedge clk);
    #4;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
